// File: rtl/mips_pkg.sv
// Shared types for the multi-cycle MIPS control path: the sequencer state
// encoding consumed by both the control FSM and the instruction decoder.
package mips_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 3'd0,
    EXEC1  = 3'd1,
    EXEC2  = 3'd2,
    MULDIV = 3'd3,
    HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/mips_wait_timer.sv
// Counts consecutive stalled memory-access cycles and flags the cycle in which
// the stall has lasted WAIT_TIMEOUT cycles; a zero timeout disables the flag.
module mips_wait_timer #(
  parameter int WAIT_TIMEOUT = 0,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic waitrequest,
  output logic timeout_hit
);

  logic [CNT_W-1:0] wait_cnt;
  logic             stalled;

  assign stalled = req & waitrequest;

  // Saturating run-length of the current stall; any unstalled cycle restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!stalled) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  generate
    if (WAIT_TIMEOUT == 0) begin : g_timeout_off
      assign timeout_hit = 1'b0;
    end else begin : g_timeout_on
      assign timeout_hit = stalled && (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle sequencer for the MIPS core: fetch/execute state register,
// HI/LO latency wait, bus wait-request timeout and datapath strobes.
module mips_control_fsm
  import mips_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32,
  parameter int WAIT_TIMEOUT = 0,
  parameter int CNT_W        = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   waitrequest,
  input  logic   halt_req,
  input  logic   is_load,
  input  logic   is_store,
  input  logic   is_mult,
  input  logic   is_div,
  output state_t state,
  output logic   active,
  output logic   ir_write,
  output logic   pc_cnt_en,
  output logic   mem_read,
  output logic   mem_write,
  output logic   muldiv_start,
  output logic   muldiv_done,
  output logic   bus_error
);

  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  generate
    if (MULT_LATENCY < 1 || DIV_LATENCY < 1) begin : g_bad_latency
      $error("mips_control_fsm: MULT_LATENCY and DIV_LATENCY must be >= 1");
    end
    if (MULT_LATENCY > CNT_MAX || DIV_LATENCY > CNT_MAX || WAIT_TIMEOUT > CNT_MAX) begin : g_bad_width
      $error("mips_control_fsm: CNT_W too narrow for the latency/timeout parameters");
    end
  endgenerate

  state_t           next_state;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] next_lat;
  logic             rd_req;
  logic             wr_req;
  logic             timeout_hit;

  // Raw access requests feed the timer before any timeout suppression.
  assign rd_req = ((state == FETCH) && !halt_req) || ((state == EXEC1) && is_load);
  assign wr_req = (state == EXEC1) && !is_load && is_store;
  assign active = (state != HALT);

  mips_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (rd_req | wr_req),
    .waitrequest(waitrequest),
    .timeout_hit(timeout_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      lat_cnt   <= '0;
      bus_error <= 1'b0;
    end else begin
      state     <= next_state;
      lat_cnt   <= next_lat;
      bus_error <= bus_error | timeout_hit;
    end
  end

  always_comb begin
    next_state   = state;
    next_lat     = lat_cnt;
    mem_read     = rd_req;
    mem_write    = wr_req;
    ir_write     = 1'b0;
    pc_cnt_en    = 1'b0;
    muldiv_start = 1'b0;
    muldiv_done  = 1'b0;
    case (state)
      FETCH: begin
        if (halt_req) begin
          next_state = HALT;
        end else if (!waitrequest) begin
          // Held low while reset is asserted so only mem_read shows in reset.
          ir_write   = reset_n;
          next_state = EXEC1;
        end
      end
      EXEC1: begin
        if (is_load) begin
          if (!waitrequest) next_state = EXEC2;
        end else if (is_store) begin
          if (!waitrequest) begin
            pc_cnt_en  = 1'b1;
            next_state = FETCH;
          end
        end else if (is_mult) begin
          muldiv_start = 1'b1;
          next_lat     = CNT_W'(MULT_LATENCY - 1);
          next_state   = MULDIV;
        end else if (is_div) begin
          muldiv_start = 1'b1;
          next_lat     = CNT_W'(DIV_LATENCY - 1);
          next_state   = MULDIV;
        end else begin
          pc_cnt_en  = 1'b1;
          next_state = FETCH;
        end
      end
      EXEC2: begin
        pc_cnt_en  = 1'b1;
        next_state = FETCH;
      end
      MULDIV: begin
        if (lat_cnt != '0) begin
          next_lat = lat_cnt - 1'b1;
        end else begin
          muldiv_done = 1'b1;
          pc_cnt_en   = 1'b1;
          next_state  = FETCH;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
    // A timed-out access aborts everything and parks the core.
    if (timeout_hit) begin
      next_state   = HALT;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      pc_cnt_en    = 1'b0;
      muldiv_start = 1'b0;
      muldiv_done  = 1'b0;
    end
  end

endmodule

// File: doc/mips_control_fsm.md
Name: mips_control_fsm

Overview:
Multi-cycle sequencer for the MIPS core. It owns the FETCH/EXEC state register, which the instruction decoder previously received as an external input. It adds a parametrised multiply/divide wait state, a wait-request timeout with a sticky bus-error halt, and cycle-accurate strobes for the instruction register, PC, memory and HI/LO unit. It sits between the memory bus handshake, the decoder (which supplies instruction-class flags) and the datapath.

Parameters:
MULT_LATENCY, 4, cycles spent in MULDIV for MULT/MULTU (must be >=1)
DIV_LATENCY, 32, cycles spent in MULDIV for DIV/DIVU (must be >=1)
WAIT_TIMEOUT, 0, consecutive waitrequest cycles before bus error; 0 disables the timeout
CNT_W, 8, width of the latency and timeout counters; must hold max(DIV_LATENCY, WAIT_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  reset, asynchronous assert, active-low
waitrequest  in  1  memory busy; the current access must be held
halt_req  in  1  PC equals 0x0, sampled in FETCH only
is_load  in  1  decoded load class (LB/LBU/LH/LHU/LW/LWL/LWR)
is_store  in  1  decoded store class (SB/SH/SW)
is_mult  in  1  MULT/MULTU
is_div  in  1  DIV/DIVU
state  out  3  FETCH=0, EXEC1=1, EXEC2=2, MULDIV=3, HALT=4
active  out  1  high in every state except HALT
ir_write  out  1  latch the instruction register
pc_cnt_en  out  1  advance the PC, one pulse per retired instruction
mem_read  out  1  memory read request
mem_write  out  1  memory write request
muldiv_start  out  1  one-cycle start pulse to the HI/LO unit
muldiv_done  out  1  one-cycle HI/LO write enable
bus_error  out  1  sticky; asserted when a timeout forced HALT

Behaviour:
- Reset (async, reset_n=0): state=FETCH, counters=0, bus_error=0, active=1. All strobes are combinational from state and inputs, so mem_read=1 during reset and every other strobe is 0.
- FETCH:
  - If halt_req: no read is issued; go to HALT next cycle.
  - Otherwise mem_read=1. While waitrequest, stay in FETCH.
  - When waitrequest is low: ir_write=1; go to EXEC1.
- EXEC1, priority load > store > mult > div > other:
  - load: mem_read=1; hold while waitrequest; then go to EXEC2.
  - store: mem_write=1; hold while waitrequest; then pc_cnt_en=1 and go to FETCH.
  - mult: muldiv_start=1; lat_cnt <= MULT_LATENCY-1; go to MULDIV.
  - div: muldiv_start=1; lat_cnt <= DIV_LATENCY-1; go to MULDIV.
  - other: pc_cnt_en=1; go to FETCH.
  - Flags are sampled only in EXEC1. Conflicting flags resolve by the priority above.
- EXEC2: pc_cnt_en=1 (load writeback cycle); go to FETCH. Always exactly one cycle.
- MULDIV: stays while lat_cnt!=0, decrementing each cycle. When lat_cnt==0: muldiv_done=1, pc_cnt_en=1, go to FETCH.
- Resulting cycles per instruction (no waits): ALU/branch/jump 2; store 2; load 3; mult 2+MULT_LATENCY; div 2+DIV_LATENCY.
- Timeout (WAIT_TIMEOUT!=0):
  - wait_cnt increments each cycle that mem_read or mem_write is high and waitrequest is high.
  - It clears on any cycle without a stalled access.
  - When wait_cnt reaches WAIT_TIMEOUT-1 with waitrequest still high: next state is HALT and bus_error is set. No other strobe fires in that cycle.
- Counter width: wait_cnt saturates and never wraps. A WAIT_TIMEOUT or DIV_LATENCY exceeding 2^CNT_W-1 is a parameter error, checked by an elaboration assertion.
- HALT: absorbing until reset. active=0, all strobes 0, bus_error holds its value.
- Reset mid-operation (e.g. MULDIV with lat_cnt=17, or a stalled load): returns to FETCH immediately. No muldiv_done or pc_cnt_en is issued.
- At most one of pc_cnt_en/ir_write is high in any cycle. mem_read and mem_write are never high together.

Decomposition:
- Shared package mips_pkg: enum state_t (FETCH, EXEC1, EXEC2, MULDIV, HALT; 3-bit encoding), plus the localparam STATE_W=3. The decoder is re-typed to consume state_t.
- Sub-module mips_wait_timer: owns wait_cnt, the saturation logic and the timeout compare, with output timeout_hit. The FSM instantiates it once.

Test Plan:
- ALU op with waitrequest low throughout: state sequence 0,1,0. ir_write in cycle 1, pc_cnt_en in cycle 2; 2 cycles per instruction.
- LW with waitrequest high for 3 cycles in EXEC1: mem_read held 4 cycles, then EXEC2 with pc_cnt_en=1; the instruction retires in 6 cycles.
- DIV with DIV_LATENCY=32: muldiv_start for 1 cycle, 32 cycles in MULDIV, then muldiv_done and pc_cnt_en together; the next FETCH comes 34 cycles after the previous one.
- WAIT_TIMEOUT=5, waitrequest stuck high in FETCH: after 5 stalled cycles state=4, bus_error=1, active=0; it stays there until reset_n is pulsed.
- halt_req=1 in FETCH: no mem_read; next state=4, bus_error=0.
- reset_n dropped asynchronously mid-MULDIV (MULT_LATENCY=4, cycle 2): state=0 immediately with no muldiv_done. After release, normal fetch resumes.
